// File: rtl/exe_stage_md_pkg.sv
// Shared encodings for the LoongArch32 execute stage with multi-cycle divide.
package exe_stage_md_pkg;

    localparam int XLEN_DEF = 32;

    // md_op fields: bit2 selects the divider, bit1 unsigned, bit0 remainder.
    localparam int MD_BIT_DIV = 2;
    localparam int MD_BIT_UNS = 1;
    localparam int MD_BIT_MOD = 0;

    localparam logic [2:0] MD_DIV_W  = 3'b100;
    localparam logic [2:0] MD_MOD_W  = 3'b101;
    localparam logic [2:0] MD_DIV_WU = 3'b110;
    localparam logic [2:0] MD_MOD_WU = 3'b111;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/exe_stage_md_alu.sv
// Single-cycle ALU with a 12-bit one-hot opcode:
// add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
module alu #(
    parameter int XLEN = 32
) (
    input  logic [11:0]     alu_op,
    input  logic [XLEN-1:0] alu_src1,
    input  logic [XLEN-1:0] alu_src2,
    output logic [XLEN-1:0] alu_result
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] w_add, w_sub, w_slt, w_sltu, w_sll, w_srl, w_sra;

    assign w_add  = alu_src1 + alu_src2;
    assign w_sub  = alu_src1 - alu_src2;
    assign w_slt  = {{(XLEN-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
    assign w_sltu = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
    assign w_sll  = alu_src1 << alu_src2[SW-1:0];
    assign w_srl  = alu_src1 >> alu_src2[SW-1:0];
    assign w_sra  = $unsigned($signed(alu_src1) >>> alu_src2[SW-1:0]);

    // One-hot opcode: AND-OR mux of every candidate result.
    assign alu_result = ({XLEN{alu_op[0]}}  & w_add)
                      | ({XLEN{alu_op[1]}}  & w_sub)
                      | ({XLEN{alu_op[2]}}  & w_slt)
                      | ({XLEN{alu_op[3]}}  & w_sltu)
                      | ({XLEN{alu_op[4]}}  & (alu_src1 & alu_src2))
                      | ({XLEN{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                      | ({XLEN{alu_op[6]}}  & (alu_src1 | alu_src2))
                      | ({XLEN{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                      | ({XLEN{alu_op[8]}}  & w_sll)
                      | ({XLEN{alu_op[9]}}  & w_srl)
                      | ({XLEN{alu_op[10]}} & w_sra)
                      | ({XLEN{alu_op[11]}} & alu_src2);

endmodule

// File: rtl/exe_stage_md_divider.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// signs restored at the output. IDLE -> BUSY (XLEN cycles) -> DONE -> IDLE.
module es_divider
    import exe_stage_md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            flush,
    input  logic            ack,
    input  logic            sign,
    input  logic            mod,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    div_state_t      r_state;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_rem, r_quo, r_div;
    logic            r_neg_q, r_neg_r, r_div0, r_mod;

    logic [XLEN-1:0] w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
    logic [XLEN:0]   w_shift, w_diff;

    assign w_abs_a = (sign && a[XLEN-1]) ? -a : a;
    assign w_abs_b = (sign && b[XLEN-1]) ? -b : b;

    // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    // Sequencing and the shift-subtract datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= DIV_IDLE;
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_mod   <= 1'b0;
        end else if (flush) begin
            r_state <= DIV_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: if (start) begin
                    r_state <= DIV_BUSY;
                    r_count <= '0;
                    r_rem   <= '0;
                    r_quo   <= w_abs_a;
                    r_div   <= w_abs_b;
                    r_neg_q <= sign && (a[XLEN-1] ^ b[XLEN-1]);
                    r_neg_r <= sign && a[XLEN-1];
                    r_div0  <= (b == '0);
                    r_mod   <= mod;
                end
                DIV_BUSY: begin
                    r_quo   <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
                    r_rem   <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(XLEN-1)) r_state <= DIV_DONE;
                end
                DIV_DONE: if (ack) r_state <= DIV_IDLE;
                default:  r_state <= DIV_IDLE;
            endcase
        end
    end

    // Zero divisor yields all-ones quotient; the remainder is then |a| and
    // regains the dividend's sign, giving back the dividend.
    assign w_quo_fix = r_div0 ? '1 : (r_neg_q ? -r_quo : r_quo);
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    assign done   = (r_state == DIV_DONE);
    assign result = r_mod ? w_rem_fix : w_quo_fix;

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage: ALU, iterative divider, sub-word store lanes, misalign
// detection, flush and a busy hint for ID hazard logic.
module exe_stage_md
    import exe_stage_md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ds_to_es_valid,
    output logic              es_allowin,
    input  logic [11:0]       ds_alu_op,
    input  logic [2:0]        ds_md_op,
    input  logic              ds_src1_is_pc,
    input  logic              ds_src2_is_imm,
    input  logic              ds_load_op,
    input  logic              ds_mem_we,
    input  logic              ds_gr_we,
    input  logic [1:0]        ds_mem_size,
    input  logic [4:0]        ds_dest,
    input  logic [XLEN-1:0]   ds_imm,
    input  logic [XLEN-1:0]   ds_rj_value,
    input  logic [XLEN-1:0]   ds_rkd_value,
    input  logic [XLEN-1:0]   ds_pc,
    input  logic              es_flush,
    input  logic              ms_allowin,
    output logic              es_to_ms_valid,
    output logic [XLEN-1:0]   es_to_ms_result,
    output logic [XLEN-1:0]   es_to_ms_pc,
    output logic [4:0]        es_to_ms_dest,
    output logic              es_to_ms_gr_we,
    output logic              es_to_ms_res_from_mem,
    output logic              es_to_ms_ale,
    output logic [1:0]        es_to_ms_mem_size,
    output logic [AW-1:0]     es_to_ms_addr_low,
    output logic [4:0]        es_to_ds_dest,
    output logic              es_to_ds_load_op,
    output logic              es_to_ds_busy,
    output logic [XLEN-1:0]   es_to_ds_result,
    output logic              data_sram_en,
    output logic [XLEN/8-1:0] data_sram_we,
    output logic [XLEN-1:0]   data_sram_addr,
    output logic [XLEN-1:0]   data_sram_wdata
);
    localparam int LANES = XLEN / 8;

    logic            r_es_valid;
    logic [11:0]     r_alu_op;
    logic [2:0]      r_md_op;
    logic            r_src1_is_pc, r_src2_is_imm, r_load_op, r_mem_we, r_gr_we;
    mem_size_t       r_mem_size;
    logic [4:0]      r_dest;
    logic [XLEN-1:0] r_imm, r_rj, r_rkd, r_pc;

    logic             w_ready_go, w_es_allowin, w_is_div, w_div_done, w_div_ack, w_mem_op, w_ale;
    logic [XLEN-1:0]  w_alu_src1, w_alu_src2, w_alu_result, w_div_result, w_result;
    logic [AW-1:0]    w_addr_low;
    logic [LANES-1:0] w_lane_mask;
    logic [XLEN-1:0]  w_wdata;

    assign w_is_div     = r_md_op[MD_BIT_DIV];
    assign w_ready_go   = w_is_div ? w_div_done : 1'b1;
    assign w_es_allowin = !r_es_valid || (w_ready_go && ms_allowin);
    assign w_div_ack    = r_es_valid && w_ready_go && ms_allowin;

    // Valid bit: flush wins, otherwise advance on allowin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)            r_es_valid <= 1'b0;
        else if (es_flush)      r_es_valid <= 1'b0;
        else if (w_es_allowin)  r_es_valid <= ds_to_es_valid;
    end

    // Instruction fields captured as the instruction enters ES.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_alu_op      <= '0;
            r_md_op       <= '0;
            r_src1_is_pc  <= 1'b0;
            r_src2_is_imm <= 1'b0;
            r_load_op     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_gr_we       <= 1'b0;
            r_mem_size    <= MEM_BYTE;
            r_dest        <= '0;
            r_imm         <= '0;
            r_rj          <= '0;
            r_rkd         <= '0;
            r_pc          <= '0;
        end else if (ds_to_es_valid && w_es_allowin) begin
            r_alu_op      <= ds_alu_op;
            r_md_op       <= ds_md_op;
            r_src1_is_pc  <= ds_src1_is_pc;
            r_src2_is_imm <= ds_src2_is_imm;
            r_load_op     <= ds_load_op;
            r_mem_we      <= ds_mem_we;
            r_gr_we       <= ds_gr_we;
            r_mem_size    <= mem_size_t'(ds_mem_size);
            r_dest        <= ds_dest;
            r_imm         <= ds_imm;
            r_rj          <= ds_rj_value;
            r_rkd         <= ds_rkd_value;
            r_pc          <= ds_pc;
        end
    end

    assign w_alu_src1 = r_src1_is_pc  ? r_pc  : r_rj;
    assign w_alu_src2 = r_src2_is_imm ? r_imm : r_rkd;

    alu #(.XLEN(XLEN)) u_alu (
        .alu_op     (r_alu_op),
        .alu_src1   (w_alu_src1),
        .alu_src2   (w_alu_src2),
        .alu_result (w_alu_result)
    );

    // Starts only while IDLE, i.e. in the first ES cycle of a divide.
    es_divider #(.XLEN(XLEN)) u_div (
        .clk    (clk),
        .resetn (resetn),
        .start  (r_es_valid && w_is_div),
        .flush  (es_flush),
        .ack    (w_div_ack),
        .sign   (!r_md_op[MD_BIT_UNS]),
        .mod    (r_md_op[MD_BIT_MOD]),
        .a      (r_rj),
        .b      (r_rkd),
        .done   (w_div_done),
        .result (w_div_result)
    );

    assign w_result   = w_is_div ? w_div_result : w_alu_result;
    assign w_addr_low = w_alu_result[AW-1:0];
    assign w_mem_op   = r_load_op || r_mem_we;
    assign w_ale      = w_mem_op &&
                        ((r_mem_size == MEM_HALF && w_alu_result[0]) ||
                         (r_mem_size == MEM_WORD && w_alu_result[1:0] != 2'b00));

    // Byte-lane mask and replicated store data by access size.
    always_comb begin
        // NOTE: defaults assigned first so every path drives both outputs and no latch is inferred.
        w_lane_mask = '1;
        w_wdata     = r_rkd;
        case (r_mem_size)
            MEM_BYTE: begin
                w_lane_mask = LANES'(1) << w_addr_low;
                w_wdata     = {LANES{r_rkd[7:0]}};
            end
            MEM_HALF: begin
                w_lane_mask = LANES'(3) << w_addr_low;
                w_wdata     = {(LANES/2){r_rkd[15:0]}};
            end
            default: ;
        endcase
    end

    assign es_allowin            = w_es_allowin;
    assign es_to_ms_valid        = r_es_valid && w_ready_go && !es_flush;
    assign es_to_ms_result       = w_result;
    assign es_to_ms_pc           = r_pc;
    assign es_to_ms_dest         = r_dest;
    assign es_to_ms_gr_we        = r_gr_we;
    assign es_to_ms_res_from_mem = r_load_op;
    assign es_to_ms_ale          = w_ale;
    assign es_to_ms_mem_size     = r_mem_size;
    assign es_to_ms_addr_low     = w_addr_low;

    assign es_to_ds_dest    = (r_es_valid && r_gr_we) ? r_dest : 5'd0;
    assign es_to_ds_load_op = r_es_valid && r_load_op;
    assign es_to_ds_busy    = r_es_valid && !w_ready_go;
    assign es_to_ds_result  = w_result;

    // The SRAM request goes out only in the cycle the access moves to MEM.
    assign data_sram_en    = r_es_valid && w_mem_op && ms_allowin && !es_flush && !w_ale;
    assign data_sram_we    = (r_mem_we && data_sram_en) ? w_lane_mask : '0;
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_wdata;

endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md: ALU path, divides with stall/hold/flush,
// and sub-word store lanes.
module tb_exe_stage_md;
    import exe_stage_md_pkg::*;

    localparam logic [11:0] OP_ADD = 12'h001;

    logic        clk, resetn;
    logic        ds_to_es_valid, es_allowin;
    logic [11:0] ds_alu_op;
    logic [2:0]  ds_md_op;
    logic        ds_src1_is_pc, ds_src2_is_imm, ds_load_op, ds_mem_we, ds_gr_we;
    logic [1:0]  ds_mem_size;
    logic [4:0]  ds_dest;
    logic [31:0] ds_imm, ds_rj_value, ds_rkd_value, ds_pc;
    logic        es_flush, ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_to_ms_result, es_to_ms_pc;
    logic [4:0]  es_to_ms_dest;
    logic        es_to_ms_gr_we, es_to_ms_res_from_mem, es_to_ms_ale;
    logic [1:0]  es_to_ms_mem_size, es_to_ms_addr_low;
    logic [4:0]  es_to_ds_dest;
    logic        es_to_ds_load_op, es_to_ds_busy;
    logic [31:0] es_to_ds_result;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata;

    int n_total = 0;
    int n_bad   = 0;

    exe_stage_md #(.XLEN(32), .AW(2)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .ds_to_es_valid        (ds_to_es_valid),
        .es_allowin            (es_allowin),
        .ds_alu_op             (ds_alu_op),
        .ds_md_op              (ds_md_op),
        .ds_src1_is_pc         (ds_src1_is_pc),
        .ds_src2_is_imm        (ds_src2_is_imm),
        .ds_load_op            (ds_load_op),
        .ds_mem_we             (ds_mem_we),
        .ds_gr_we              (ds_gr_we),
        .ds_mem_size           (ds_mem_size),
        .ds_dest               (ds_dest),
        .ds_imm                (ds_imm),
        .ds_rj_value           (ds_rj_value),
        .ds_rkd_value          (ds_rkd_value),
        .ds_pc                 (ds_pc),
        .es_flush              (es_flush),
        .ms_allowin            (ms_allowin),
        .es_to_ms_valid        (es_to_ms_valid),
        .es_to_ms_result       (es_to_ms_result),
        .es_to_ms_pc           (es_to_ms_pc),
        .es_to_ms_dest         (es_to_ms_dest),
        .es_to_ms_gr_we        (es_to_ms_gr_we),
        .es_to_ms_res_from_mem (es_to_ms_res_from_mem),
        .es_to_ms_ale          (es_to_ms_ale),
        .es_to_ms_mem_size     (es_to_ms_mem_size),
        .es_to_ms_addr_low     (es_to_ms_addr_low),
        .es_to_ds_dest         (es_to_ds_dest),
        .es_to_ds_load_op      (es_to_ds_load_op),
        .es_to_ds_busy         (es_to_ds_busy),
        .es_to_ds_result       (es_to_ds_result),
        .data_sram_en          (data_sram_en),
        .data_sram_we          (data_sram_we),
        .data_sram_addr        (data_sram_addr),
        .data_sram_wdata       (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=summary");
        $fatal(1, "simulation did not terminate");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_ds();
        ds_to_es_valid = 1'b0;
        ds_alu_op      = '0;
        ds_md_op       = '0;
        ds_src1_is_pc  = 1'b0;
        ds_src2_is_imm = 1'b0;
        ds_load_op     = 1'b0;
        ds_mem_we      = 1'b0;
        ds_gr_we       = 1'b0;
        ds_mem_size    = 2'd0;
        ds_dest        = '0;
        ds_imm         = '0;
        ds_rj_value    = '0;
        ds_rkd_value   = '0;
        ds_pc          = '0;
    endtask

    task automatic drive_op(input logic [11:0] op, input logic [2:0] md,
                            input logic [31:0] rj, input logic [31:0] rkd, input logic [4:0] dest);
        clear_ds();
        ds_to_es_valid = 1'b1;
        ds_alu_op      = op;
        ds_md_op       = md;
        ds_rj_value    = rj;
        ds_rkd_value   = rkd;
        ds_gr_we       = 1'b1;
        ds_dest        = dest;
        ds_pc          = 32'h1c00_0000;
    endtask

    // Waits (bounded) for es_to_ms_valid, counting busy cycles before it.
    task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_busy);
        int busy_n = 0;
        int gap    = 0;
        bit seen   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk); #1;
            if (es_to_ms_valid) seen = 1'b1;
            else if (es_to_ds_busy) busy_n++;
            else gap++;
        end
        check({tag, "_valid"}, seen, 1);
        check({tag, "_res"}, es_to_ms_result, exp);
        check({tag, "_fwd"}, es_to_ds_result, exp);
        check({tag, "_busy_cycles"}, busy_n, exp_busy);
        check({tag, "_idle_gap"}, gap, 0);
    endtask

    task automatic run_md(input string tag, input logic [2:0] md,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        drive_op('0, md, a, b, 5'd10);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        wait_result(tag, exp, 33);
        @(posedge clk);
    endtask

    task automatic run_mem(input string tag, input logic ld, input logic st, input logic [1:0] size,
                           input logic [31:0] rj, input logic [31:0] imm, input logic [31:0] rkd,
                           input logic exp_en, input logic [3:0] exp_we,
                           input logic [31:0] exp_wdata, input logic exp_ale);
        @(negedge clk);
        clear_ds();
        ds_to_es_valid = 1'b1;
        ds_alu_op      = OP_ADD;
        ds_src2_is_imm = 1'b1;
        ds_load_op     = ld;
        ds_mem_we      = st;
        ds_gr_we       = ld;
        ds_dest        = ld ? 5'd8 : 5'd0;
        ds_mem_size    = size;
        ds_rj_value    = rj;
        ds_imm         = imm;
        ds_rkd_value   = rkd;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        @(negedge clk); #1;
        check({tag, "_addr"}, data_sram_addr, rj + imm);
        check({tag, "_addr_low"}, es_to_ms_addr_low, imm[1:0]);
        check({tag, "_en"}, data_sram_en, exp_en);
        check({tag, "_we"}, data_sram_we, exp_we);
        check({tag, "_wdata"}, data_sram_wdata, exp_wdata);
        check({tag, "_ale"}, es_to_ms_ale, exp_ale);
        check({tag, "_ld_hint"}, es_to_ds_load_op, ld);
        check({tag, "_ds_dest"}, es_to_ds_dest, ld ? 5'd8 : 5'd0);
        @(posedge clk);
    endtask

    initial begin
        resetn     = 1'b0;
        es_flush   = 1'b0;
        ms_allowin = 1'b1;
        clear_ds();

        // Reset state
        #12;
        check("rst_valid", es_to_ms_valid, 0);
        check("rst_en", data_sram_en, 0);
        check("rst_we", data_sram_we, 0);
        check("rst_busy", es_to_ds_busy, 0);
        check("rst_ds_dest", es_to_ds_dest, 0);
        check("rst_allowin", es_allowin, 1);
        @(negedge clk);
        resetn = 1'b1;

        // 1: add.w 5 + 7
        @(negedge clk);
        drive_op(OP_ADD, 3'b000, 32'd5, 32'd7, 5'd3);
        #1 check("add_allowin_in", es_allowin, 1);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        wait_result("add", 32'd12, 0);
        check("add_allowin", es_allowin, 1);
        check("add_ds_dest", es_to_ds_dest, 5'd3);
        @(posedge clk);

        // 2: div.w then mod.w back-to-back, -7 / 2
        @(negedge clk);
        drive_op('0, MD_DIV_W, 32'hFFFF_FFF9, 32'd2, 5'd4);
        @(posedge clk); #1;
        drive_op('0, MD_MOD_W, 32'hFFFF_FFF9, 32'd2, 5'd5);
        wait_result("div_w", 32'hFFFF_FFFD, 33);
        check("div_w_ds_dest", es_to_ds_dest, 5'd4);
        check("div_w_allowin", es_allowin, 1);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        wait_result("mod_w", 32'hFFFF_FFFF, 33);
        @(posedge clk);

        // 3: divide corner cases
        run_md("divwu_zero", MD_DIV_WU, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_md("modwu_zero", MD_MOD_WU, 32'd100, 32'd0, 32'd100);
        run_md("divw_ovf",   MD_DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("modw_ovf",   MD_MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_md("divw_zero",  MD_DIV_W,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_md("modw_zero",  MD_MOD_W,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run_md("divwu_big",  MD_DIV_WU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);

        // 4: DONE held while MEM back-pressures
        @(negedge clk);
        ms_allowin = 1'b0;
        drive_op('0, MD_DIV_W, 32'd100, 32'd7, 5'd6);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        wait_result("hold", 32'd14, 33);
        check("hold_allowin0", es_allowin, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("hold_valid", es_to_ms_valid, 1);
            check("hold_res", es_to_ms_result, 32'd14);
            check("hold_allowin", es_allowin, 0);
        end
        ms_allowin = 1'b1;
        #1 check("hold_release_allowin", es_allowin, 1);
        @(posedge clk);
        @(negedge clk); #1;
        check("hold_after_valid", es_to_ms_valid, 0);
        check("hold_after_allowin", es_allowin, 1);

        // 5: flush during BUSY, then new instructions
        @(negedge clk);
        drive_op('0, MD_DIV_W, 32'd1000, 32'd3, 5'd7);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        repeat (11) @(negedge clk);
        #1 check("flush_busy_before", es_to_ds_busy, 1);
        es_flush = 1'b1;
        #1 check("flush_valid_out", es_to_ms_valid, 0);
        @(negedge clk);
        es_flush = 1'b0;
        #1;
        check("flush_allowin", es_allowin, 1);
        check("flush_busy", es_to_ds_busy, 0);
        check("flush_ds_dest", es_to_ds_dest, 0);
        drive_op(OP_ADD, 3'b000, 32'd3, 32'd4, 5'd9);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        wait_result("flush_add", 32'd7, 0);
        @(posedge clk);
        run_md("flush_div", MD_DIV_W, 32'd9, 32'd3, 32'd3);

        // 6: memory lanes and misalignment
        run_mem("st_b3",  1'b0, 1'b1, MEM_BYTE, 32'h1000, 32'd3, 32'h0000_00AB, 1'b1, 4'b1000, 32'hABAB_ABAB, 1'b0);
        run_mem("st_h2",  1'b0, 1'b1, MEM_HALF, 32'h1000, 32'd2, 32'h0000_1234, 1'b1, 4'b1100, 32'h1234_1234, 1'b0);
        run_mem("st_w2",  1'b0, 1'b1, MEM_WORD, 32'h1000, 32'd2, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'hDEAD_BEEF, 1'b1);
        run_mem("st_h1",  1'b0, 1'b1, MEM_HALF, 32'h1000, 32'd1, 32'h0000_1234, 1'b0, 4'b0000, 32'h1234_1234, 1'b1);
        run_mem("st_b1",  1'b0, 1'b1, MEM_BYTE, 32'h1000, 32'd1, 32'h0000_005A, 1'b1, 4'b0010, 32'h5A5A_5A5A, 1'b0);
        run_mem("st_w0",  1'b0, 1'b1, MEM_WORD, 32'h1000, 32'd0, 32'h0102_0304, 1'b1, 4'b1111, 32'h0102_0304, 1'b0);
        run_mem("ld_w4",  1'b1, 1'b0, MEM_WORD, 32'h1000, 32'd4, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
